id_decode_queue: RTL

Parametrised instruction-decode stage with a small instruction queue, a registered decode output and a load-use interlock. It sits between fetch and execute and replaces the unbuffered single-register decoder. Fetch pushes 16-bit instructions with a valid/ready handshake. Execute consumes decoded register indices and jump control with valid/ready. Register-index width, queue depth and special-register indices are parameters.

---
 rtl/id_decode_queue_pkg.sv | 59 +++++
 rtl/id_decode_queue_if.sv | 24 ++
 rtl/id_decode_comb.sv | 65 ++++++
 rtl/id_decode_queue.sv | 124 ++++++++++++
 4 files changed

// File: rtl/id_decode_queue_pkg.sv
// Shared decode definitions: jump codes, opcodes, operand selectors and the decoded-fields struct.
package decode_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EQZ  = 3'd1,
    NEZ  = 3'd2,
    TEQZ = 3'd3,
    TNEZ = 3'd4,
    JUMP = 3'd5,
    DB   = 3'd6
  } jump_e;

  // Operands are decoded to symbolic sources so the decoder stays width-independent.
  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_F1,
    SEL_F2,
    SEL_F3,
    SEL_SP,
    SEL_IH,
    SEL_NONE
  } sel_e;

  localparam logic [4:0] OP_ADDSP  = 5'b00000;
  localparam logic [4:0] OP_DB     = 5'b00010;
  localparam logic [4:0] OP_BEQZ   = 5'b00100;
  localparam logic [4:0] OP_BNEZ   = 5'b00101;
  localparam logic [4:0] OP_SHIFT  = 5'b00110;
  localparam logic [4:0] OP_ADDIU3 = 5'b01000;
  localparam logic [4:0] OP_ADDIU  = 5'b01001;
  localparam logic [4:0] OP_SLTI   = 5'b01010;
  localparam logic [4:0] OP_SPEC   = 5'b01100;
  localparam logic [4:0] OP_LI     = 5'b01101;
  localparam logic [4:0] OP_MOVE   = 5'b01111;
  localparam logic [4:0] OP_LWSP   = 5'b10010;
  localparam logic [4:0] OP_LW     = 5'b10011;
  localparam logic [4:0] OP_SWSP   = 5'b11010;
  localparam logic [4:0] OP_SW     = 5'b11011;
  localparam logic [4:0] OP_RRR    = 5'b11100;
  localparam logic [4:0] OP_ALU    = 5'b11101;
  localparam logic [4:0] OP_IH     = 5'b11110;

  localparam logic [2:0] SPEC_TEQZ  = 3'b000;
  localparam logic [2:0] SPEC_TNEZ  = 3'b001;
  localparam logic [2:0] SPEC_SP    = 3'b011;
  localparam logic [2:0] SPEC_MTSP  = 3'b100;

  localparam logic [15:0] NOP_WORD = 16'h0800;

  typedef struct packed {
    sel_e  x;
    sel_e  y;
    sel_e  z;
    jump_e jump;
    logic  is_load;
  } dec_t;

endpackage

// File: rtl/id_decode_queue_if.sv
// Fetch-side push and execute-side issue signals of the decode stage.
interface id_decode_queue_if #(parameter int REG_W = 4);
  logic             flush;
  logic             if_valid;
  logic [15:0]      if_instr;
  logic             if_ready;
  logic             ex_ready;
  logic             id_valid;
  logic [REG_W-1:0] id_reg_x;
  logic [REG_W-1:0] id_reg_y;
  logic [REG_W-1:0] id_reg_z;
  logic [2:0]       id_jump;
  logic             id_is_load;

  modport slave (
    input  flush, if_valid, if_instr, ex_ready,
    output if_ready, id_valid, id_reg_x, id_reg_y, id_reg_z, id_jump, id_is_load
  );

  modport master (
    output flush, if_valid, if_instr, ex_ready,
    input  if_ready, id_valid, id_reg_x, id_reg_y, id_reg_z, id_jump, id_is_load
  );
endinterface

// File: rtl/id_decode_comb.sv
// Pure combinational instruction decoder producing symbolic operand sources and jump/load flags.
module id_decode_comb
  import decode_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec
);

  always_comb begin
    dec = '{x: SEL_ZERO, y: SEL_ZERO, z: SEL_NONE, jump: IDLE, is_load: 1'b0};
    case (instr[15:11])
      OP_ADDSP:  begin dec.x = SEL_SP; dec.z = SEL_F1; end
      OP_DB:     dec.jump = DB;
      OP_BEQZ:   begin dec.x = SEL_F1; dec.jump = EQZ; end
      OP_BNEZ:   begin dec.x = SEL_F1; dec.jump = NEZ; end
      OP_SHIFT:  begin dec.x = SEL_F2; dec.z = SEL_F1; end
      OP_ADDIU3: begin dec.x = SEL_F1; dec.z = SEL_F2; end
      OP_ADDIU:  begin dec.x = SEL_F1; dec.z = SEL_F1; end
      OP_SLTI:   dec.x = SEL_F1;
      OP_SPEC: begin
        case (instr[10:8])
          SPEC_TEQZ: dec.jump = TEQZ;
          SPEC_TNEZ: dec.jump = TNEZ;
          SPEC_SP:   begin dec.x = SEL_SP; dec.z = SEL_SP; end
          SPEC_MTSP: begin dec.x = SEL_F2; dec.z = SEL_SP; end
          default: ;
        endcase
      end
      OP_LI:     dec.z = SEL_F1;
      OP_MOVE:   begin dec.x = SEL_F2; dec.z = SEL_F1; end
      OP_LWSP:   begin dec.y = SEL_SP; dec.z = SEL_F1; dec.is_load = 1'b1; end
      OP_LW:     begin dec.y = SEL_F1; dec.z = SEL_F2; dec.is_load = 1'b1; end
      OP_SWSP:   begin dec.x = SEL_F1; dec.y = SEL_SP; end
      OP_SW:     begin dec.x = SEL_F2; dec.y = SEL_F1; end
      OP_RRR:    begin dec.x = SEL_F1; dec.y = SEL_F2; dec.z = SEL_F3; end
      OP_ALU: begin
        case (instr[4:0])
          5'b00000: begin
            if (instr[7:5] == 3'b000) begin
              dec.x = SEL_F1;
              dec.jump = JUMP;
            end else if (instr[7:5] == 3'b010) begin
              dec.z = SEL_F1;
            end
          end
          5'b00110, 5'b00111: begin dec.x = SEL_F2; dec.y = SEL_F1; dec.z = SEL_F2; end
          5'b01010:           begin dec.x = SEL_F2; dec.y = SEL_F1; end
          5'b01100, 5'b01101: begin dec.x = SEL_F2; dec.y = SEL_F1; dec.z = SEL_F1; end
          default: ;
        endcase
      end
      OP_IH: begin
        if (instr[0]) begin
          dec.x = SEL_F1;
          dec.z = SEL_IH;
        end else begin
          dec.x = SEL_IH;
          dec.z = SEL_F1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_decode_queue.sv
// Decode stage: instruction queue, head decode, registered issue output.
// Optional load-use interlock enabled by defining LOAD_USE_STALL_EN.
module id_decode_queue
  import decode_pkg::*;
#(
  parameter int REG_W    = 4,
  parameter int DEPTH    = 2,
  parameter int SP_IDX   = 9,
  parameter int IH_IDX   = 8,
  parameter int NONE_IDX = 2**REG_W - 1
) (
  input logic               clk,
  input logic               rst,
  id_decode_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic             valid_reg;
  logic [REG_W-1:0] x_reg, y_reg, z_reg;
  jump_e            jump_reg;
  logic             load_reg;

  logic [15:0]      head;
  dec_t             head_dec;
  logic [REG_W-1:0] head_x, head_y, head_z;
  logic             if_ready, push, pop, out_free, empty, stall;

  function automatic logic [REG_W-1:0] resolve(input sel_e s, input logic [15:0] w);
    logic [REG_W-1:0] r;
    case (s)
      SEL_F1:   r = {{(REG_W-3){1'b0}}, w[10:8]};
      SEL_F2:   r = {{(REG_W-3){1'b0}}, w[7:5]};
      SEL_F3:   r = {{(REG_W-3){1'b0}}, w[4:2]};
      SEL_SP:   r = REG_W'(SP_IDX);
      SEL_IH:   r = REG_W'(IH_IDX);
      SEL_NONE: r = REG_W'(NONE_IDX);
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign head = mem[rd_ptr_reg];

  id_decode_comb u_decode (
    .instr (head),
    .dec   (head_dec)
  );

  assign head_x = resolve(head_dec.x, head);
  assign head_y = resolve(head_dec.y, head);
  assign head_z = resolve(head_dec.z, head);

  assign if_ready = count_reg < CNT_W'(DEPTH);
  assign empty    = count_reg == '0;
  assign out_free = !valid_reg || bus.ex_ready;
  assign push     = bus.if_valid && if_ready;
  assign pop      = !empty && !stall && out_free;

`ifdef LOAD_USE_STALL_EN
  // A load leaving this cycle cannot feed the very next instruction; hold it back one cycle.
  assign stall = valid_reg && load_reg && (z_reg != REG_W'(NONE_IDX)) && bus.ex_ready &&
                 ((head_x == z_reg) || (head_y == z_reg));
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem[wr_ptr_reg] <= bus.if_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
      z_reg      <= REG_W'(NONE_IDX);
      jump_reg   <= IDLE;
      load_reg   <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
      if (pop) begin
        valid_reg <= 1'b1;
        x_reg     <= head_x;
        y_reg     <= head_y;
        z_reg     <= head_z;
        jump_reg  <= head_dec.jump;
        load_reg  <= head_dec.is_load;
      end else if (out_free) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.if_ready   = if_ready;
  assign bus.id_valid   = valid_reg;
  assign bus.id_reg_x   = x_reg;
  assign bus.id_reg_y   = y_reg;
  assign bus.id_reg_z   = z_reg;
  assign bus.id_jump    = jump_reg;
  assign bus.id_is_load = load_reg;

endmodule
